ram_dp_pipe: RTL

//   Parametrised simple-dual-port synchronous RAM: one write port and one read port
//   on a single clock, with byte enables and selectable read latency (1 or 2).

---
 rtl/ram_pkg.sv | 29 ++
 rtl/ram_init_seq.sv | 74 +++++++
 rtl/ram_dp_pipe.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/ram_pkg.sv
// ============================================================================
// Module  : ram_pkg
// Brief   : Shared types, RDW mode constants and byte-merge helper for ram_dp_pipe.
// Revision: 1.0
// ============================================================================
`default_nettype none

package ram_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } ram_state_e;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    // One byte lane of a byte-enabled merge; callers replicate it per lane.
    function automatic logic [7:0] be_merge(
        input logic [7:0] old_byte,
        input logic [7:0] new_byte,
        input logic       be
    );
        return be ? new_byte : old_byte;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ram_init_seq.sv
// ============================================================================
// Module  : ram_init_seq
// Brief   : Post-reset clear sequencer: walks every word once, then raises ready.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ram_init_seq #(
    parameter int DEPTH          = 32768,
    parameter int AW             = $clog2(DEPTH),
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          ready,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    import ram_pkg::*;

    localparam logic [AW-1:0] c_LAST = AW'(DEPTH - 1);

    ram_state_e    r_state;
    ram_state_e    w_state_nxt;
    logic [AW-1:0] r_cnt;
    logic [AW-1:0] w_cnt_nxt;
    logic          r_ready;

    // ready is registered from the next state so it is low throughout reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ready <= (w_state_nxt == READY);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        clr_we      = 1'b0;
        case (r_state)
            CLEAR: begin
                if (CLEAR_ON_RESET != 0) begin
                    clr_we    = 1'b1;
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        w_state_nxt = READY;
                        w_cnt_nxt   = r_cnt;
                    end
                end else begin
                    w_state_nxt = READY;
                end
            end
            READY: begin
                w_state_nxt = READY;
            end
            default: begin
                w_state_nxt = CLEAR;
            end
        endcase
    end

    assign ready    = r_ready;
    assign clr_addr = r_cnt;

endmodule

`default_nettype wire

// File: rtl/ram_dp_pipe.sv
// ============================================================================
// Module  : ram_dp_pipe
// Brief   : Simple dual-port byte-enabled RAM, read latency 1 or 2, defined RDW.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ram_dp_pipe #(
    parameter int DW             = 16,
    parameter int DEPTH          = 32768,
    parameter int AW             = $clog2(DEPTH),
    parameter int READ_LATENCY   = 1,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            ready,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [DW-1:0]   wr_data,
    input  logic [DW/8-1:0] wr_be,
    input  logic            rd_en,
    input  logic [AW-1:0]   rd_addr,
    output logic [DW-1:0]   rd_data,
    output logic            rd_valid
);

    import ram_pkg::*;

    localparam int          c_NB    = DW / 8;
    localparam logic [AW:0] c_DEPTH = (AW + 1)'(DEPTH);

    logic            w_ready;
    logic            w_clr_we;
    logic [AW-1:0]   w_clr_addr;

    logic            w_we;
    logic [AW-1:0]   w_addr;
    logic [DW-1:0]   w_wdata;
    logic [c_NB-1:0] w_be;

    logic            w_rd_go;
    logic            w_rd_in_range;
    logic            w_rdw_hit;
    logic [DW-1:0]   w_rd_word;
    logic [DW-1:0]   w_merged;
    logic [DW-1:0]   w_rd_next;

    logic [DW-1:0]   r_mem [DEPTH];
    logic            r_v1;
    logic [DW-1:0]   r_d1;

    ram_init_seq #(
        .DEPTH          (DEPTH),
        .AW             (AW),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_init_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .ready    (w_ready),
        .clr_we   (w_clr_we),
        .clr_addr (w_clr_addr)
    );

    // The clear sequencer owns the write port until ready; user traffic after
    always_comb begin
        if (w_ready) begin
            w_we    = wr_en && ({1'b0, wr_addr} < c_DEPTH);
            w_addr  = wr_addr;
            w_wdata = wr_data;
            w_be    = wr_be;
        end else begin
            w_we    = w_clr_we;
            w_addr  = w_clr_addr;
            w_wdata = '0;
            w_be    = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int i = 0; i < c_NB; i++) begin
                if (w_be[i]) begin
                    r_mem[w_addr][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

    assign w_rd_go       = rd_en && w_ready;
    assign w_rd_in_range = ({1'b0, rd_addr} < c_DEPTH);
    assign w_rd_word     = r_mem[rd_addr];
    assign w_rdw_hit     = w_we && (w_addr == rd_addr);

    generate
        for (genvar b = 0; b < c_NB; b++) begin : g_byte
            assign w_merged[8*b +: 8] = be_merge(w_rd_word[8*b +: 8], w_wdata[8*b +: 8], w_be[b]);
        end
    endgenerate

    always_comb begin
        w_rd_next = w_rd_word;
        if (!w_rd_in_range) begin
            w_rd_next = '0;
        end else if ((RDW_MODE == RDW_NEW) && w_rdw_hit) begin
            w_rd_next = w_merged;
        end
    end

    // Data registers only load on a request so rd_data holds between reads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1 <= 1'b0;
            r_d1 <= '0;
        end else begin
            r_v1 <= w_rd_go;
            if (w_rd_go) begin
                r_d1 <= w_rd_next;
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic          r_v2;
            logic [DW-1:0] r_d2;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_v2 <= 1'b0;
                    r_d2 <= '0;
                end else begin
                    r_v2 <= r_v1;
                    if (r_v1) begin
                        r_d2 <= r_d1;
                    end
                end
            end

            assign rd_valid = r_v2;
            assign rd_data  = r_d2;
        end else begin : g_lat1
            assign rd_valid = r_v1;
            assign rd_data  = r_d1;
        end
    endgenerate

    assign ready = w_ready;

endmodule

`default_nettype wire
